// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Free-running VGA raster timing generator. A clock divider produces one
//   pixel strobe every CLK_DIV system clocks. Horizontal and vertical counters
//   advance on that strobe. Hsync and Vsync are decoded from the counters and
//   then registered. This gives them the same 1-clk lag as the registered
//   active flag in the downstream colour stage.
//
//   Each axis is ordered: sync, back porch, active, front porch.
//
// Ports
//   Clk             in   system clock
//   Rst             in   synchronous active-high reset (overrides En)
//   En              in   1 = run, 0 = freeze divider and counters
//   Pix_tick        out  1-clk strobe, one per pixel period (0 while frozen)
//   Count_h         out  horizontal pixel counter, 0..H_TOTAL-1
//   Count_v         out  vertical line counter, 0..V_TOTAL-1
//   H_left_margin   out  first visible Count_h  (H_SYNC+H_BP)
//   H_right_margin  out  last visible Count_h   (H_SYNC+H_BP+H_ACTIVE-1)
//   V_left_margin   out  first visible Count_v  (V_SYNC+V_BP)
//   V_right_margin  out  last visible Count_v   (V_SYNC+V_BP+V_ACTIVE-1)
//   Hsync           out  registered horizontal sync, active level HS_POL
//   Vsync           out  registered vertical sync, active level VS_POL
//   Frame_start     out  registered 1-clk pulse after the (0,0) wrap
//
// REZ_MAX_WIDTH must be wide enough to hold H_TOTAL-1 and V_TOTAL-1.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int REZ_MAX_WIDTH = 11,
  parameter int CLK_DIV       = 4,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33,
  parameter int V_ACTIVE      = 480,
  parameter int V_FP          = 10,
  parameter int HS_POL        = 0,
  parameter int VS_POL        = 0
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     En,
  output logic                     Pix_tick,
  output logic [REZ_MAX_WIDTH-1:0] Count_h,
  output logic [REZ_MAX_WIDTH-1:0] Count_v,
  output logic [REZ_MAX_WIDTH-1:0] H_left_margin,
  output logic [REZ_MAX_WIDTH-1:0] H_right_margin,
  output logic [REZ_MAX_WIDTH-1:0] V_left_margin,
  output logic [REZ_MAX_WIDTH-1:0] V_right_margin,
  output logic                     Hsync,
  output logic                     Vsync,
  output logic                     Frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  // Keep the divider at least 1 bit wide so that CLK_DIV == 1 still elaborates.
  // In that case the divider sits at 0 and every enabled clk is a tick.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]         DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]         DIV_ONE  = DIV_W'(1);
  localparam logic [REZ_MAX_WIDTH-1:0] CNT_ONE  = REZ_MAX_WIDTH'(1);
  localparam logic [REZ_MAX_WIDTH-1:0] H_LAST   = REZ_MAX_WIDTH'(H_TOTAL - 1);
  localparam logic [REZ_MAX_WIDTH-1:0] V_LAST   = REZ_MAX_WIDTH'(V_TOTAL - 1);
  localparam logic [REZ_MAX_WIDTH-1:0] H_SYNC_W = REZ_MAX_WIDTH'(H_SYNC);
  localparam logic [REZ_MAX_WIDTH-1:0] V_SYNC_W = REZ_MAX_WIDTH'(V_SYNC);
  localparam logic                     HS_ACT   = (HS_POL != 0) ? 1'b1 : 1'b0;
  localparam logic                     VS_ACT   = (VS_POL != 0) ? 1'b1 : 1'b0;

  // The margins are pure parameter constants, so reset does not affect them.
  assign H_left_margin  = REZ_MAX_WIDTH'(H_SYNC + H_BP);
  assign H_right_margin = REZ_MAX_WIDTH'(H_SYNC + H_BP + H_ACTIVE - 1);
  assign V_left_margin  = REZ_MAX_WIDTH'(V_SYNC + V_BP);
  assign V_right_margin = REZ_MAX_WIDTH'(V_SYNC + V_BP + V_ACTIVE - 1);

  logic [DIV_W-1:0] div_q;
  logic             line_end;
  logic             frame_end;
  logic             hsync_next;
  logic             vsync_next;
  logic             wrap_q;     // set for one clk after the counters wrap to (0,0)

  // NOTE: every signal assigned in always_comb gets a default value first,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    Pix_tick   = 1'b0;
    line_end   = 1'b0;
    frame_end  = 1'b0;
    hsync_next = ~HS_ACT;
    vsync_next = ~VS_ACT;

    // Gating with Rst keeps the strobe low while reset is held, even when
    // CLK_DIV == 1.
    if (En && !Rst && (div_q == DIV_LAST)) Pix_tick = 1'b1;

    if (Count_h == H_LAST) line_end = 1'b1;
    if (line_end && (Count_v == V_LAST)) frame_end = 1'b1;

    // Vsync covers whole lines, because it depends only on Count_v.
    if (Count_h < H_SYNC_W) hsync_next = HS_ACT;
    if (Count_v < V_SYNC_W) vsync_next = VS_ACT;
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples values from before the edge, regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      div_q       <= '0;
      Count_h     <= '0;
      Count_v     <= '0;
      Hsync       <= ~HS_ACT;
      Vsync       <= ~VS_ACT;
      wrap_q      <= 1'b0;
      Frame_start <= 1'b0;
    end else begin
      if (Pix_tick) begin
        div_q <= '0;
        if (line_end) begin
          Count_h <= '0;
          Count_v <= frame_end ? '0 : (Count_v + CNT_ONE);
        end else begin
          Count_h <= Count_h + CNT_ONE;
        end
      end else if (En) begin
        div_q <= div_q + DIV_ONE;
      end

      // The syncs keep decoding the counters while En is low. Frozen counters
      // therefore give frozen syncs.
      Hsync <= hsync_next;
      Vsync <= vsync_next;

      // Frame_start is delayed by one clk after the wrap. This aligns it with
      // the first registered sync of the new frame.
      wrap_q      <= Pix_tick & frame_end;
      Frame_start <= wrap_q;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Two small-geometry instances run side by side from one Rst/En stream.
//   Instance 0: CLK_DIV=4, active-low syncs.
//   Instance 1: CLK_DIV=1, active-high hsync.
//
//   The reference model does not track the counters directly. It counts
//   enabled clks since reset. From that count it derives, with division and
//   modulo, the tick count, the raster position, the syncs and the frame pulses.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int W  = 11;
  localparam int NI = 2;

  localparam int A_DIV = 4, A_HS = 3, A_HBP = 2, A_HA = 6, A_HFP = 2;
  localparam int A_VS  = 2, A_VBP = 2, A_VA = 4, A_VFP = 1;
  localparam int B_DIV = 1, B_HS = 4, B_HBP = 3, B_HA = 8, B_HFP = 2;
  localparam int B_VS  = 2, B_VBP = 1, B_VA = 3, B_VFP = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  logic [W-1:0] ch  [NI];
  logic [W-1:0] cv  [NI];
  logic [W-1:0] hlm [NI];
  logic [W-1:0] hrm [NI];
  logic [W-1:0] vlm [NI];
  logic [W-1:0] vrm [NI];
  logic         pt  [NI];
  logic         hs  [NI];
  logic         vs  [NI];
  logic         fs  [NI];

  always #5 clk = ~clk;

  vga_timing_gen #(
    .REZ_MAX_WIDTH(W), .CLK_DIV(A_DIV),
    .H_SYNC(A_HS), .H_BP(A_HBP), .H_ACTIVE(A_HA), .H_FP(A_HFP),
    .V_SYNC(A_VS), .V_BP(A_VBP), .V_ACTIVE(A_VA), .V_FP(A_VFP),
    .HS_POL(0), .VS_POL(0)
  ) u_dut_a (
    .Clk(clk), .Rst(rst), .En(en), .Pix_tick(pt[0]),
    .Count_h(ch[0]), .Count_v(cv[0]),
    .H_left_margin(hlm[0]), .H_right_margin(hrm[0]),
    .V_left_margin(vlm[0]), .V_right_margin(vrm[0]),
    .Hsync(hs[0]), .Vsync(vs[0]), .Frame_start(fs[0])
  );

  vga_timing_gen #(
    .REZ_MAX_WIDTH(W), .CLK_DIV(B_DIV),
    .H_SYNC(B_HS), .H_BP(B_HBP), .H_ACTIVE(B_HA), .H_FP(B_HFP),
    .V_SYNC(B_VS), .V_BP(B_VBP), .V_ACTIVE(B_VA), .V_FP(B_VFP),
    .HS_POL(1), .VS_POL(0)
  ) u_dut_b (
    .Clk(clk), .Rst(rst), .En(en), .Pix_tick(pt[1]),
    .Count_h(ch[1]), .Count_v(cv[1]),
    .H_left_margin(hlm[1]), .H_right_margin(hrm[1]),
    .V_left_margin(vlm[1]), .V_right_margin(vrm[1]),
    .Hsync(hs[1]), .Vsync(vs[1]), .Frame_start(fs[1])
  );

  // Per-instance geometry, as seen by the model.
  int m_div [NI], m_hsl [NI], m_hbp [NI], m_ha [NI], m_ht [NI];
  int m_vsl [NI], m_vbp [NI], m_va [NI], m_vt [NI];
  logic m_hpol [NI], m_vpol [NI];

  // Model state.
  longint m_en_clks [NI];  // enabled clks since the last reset
  logic   m_hs  [NI];
  logic   m_vs  [NI];
  logic   m_fp1 [NI];
  logic   m_fs  [NI];
  bit     model_ok = 1'b0;

  // Frame-pulse spacing measurement, valid only over uninterrupted runs.
  longint cyc = 0;
  longint last_fs [NI];
  longint gap [NI];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint ticks_of(input int i);
    return m_en_clks[i] / m_div[i];
  endfunction

  function automatic longint pos_h(input int i);
    return ticks_of(i) % m_ht[i];
  endfunction

  function automatic longint pos_v(input int i);
    return (ticks_of(i) / m_ht[i]) % m_vt[i];
  endfunction

  // Apply inputs at the negedge and compare shortly after. Then advance the
  // model across the following posedge.
  task automatic cycle(input logic r, input logic e);
    logic exp_pt;
    longint h_now, v_now;
    @(negedge clk);
    rst = r;
    en  = e;
    #1;
    for (int i = 0; i < NI; i++) begin
      exp_pt = e && !r && ((m_en_clks[i] % m_div[i]) == m_div[i] - 1);
      if (model_ok) begin
        check($sformatf("count_h[%0d]", i), 64'(ch[i]), 64'(pos_h(i)));
        check($sformatf("count_v[%0d]", i), 64'(cv[i]), 64'(pos_v(i)));
        check($sformatf("pix_tick[%0d]", i), 64'(pt[i]), 64'(exp_pt));
        check($sformatf("hsync[%0d]", i), 64'(hs[i]), 64'(m_hs[i]));
        check($sformatf("vsync[%0d]", i), 64'(vs[i]), 64'(m_vs[i]));
        check($sformatf("frame_start[%0d]", i), 64'(fs[i]), 64'(m_fs[i]));
      end
      if (r || !e) last_fs[i] = -1;
      else if (fs[i] === 1'b1) begin
        if (last_fs[i] >= 0) gap[i] = cyc - last_fs[i];
        last_fs[i] = cyc;
      end
    end
    @(posedge clk);
    cyc++;
    for (int i = 0; i < NI; i++) begin
      if (r) begin
        m_en_clks[i] = 0;
        m_hs[i]  = ~m_hpol[i];
        m_vs[i]  = ~m_vpol[i];
        m_fp1[i] = 1'b0;
        m_fs[i]  = 1'b0;
      end else begin
        h_now = pos_h(i);
        v_now = pos_v(i);
        exp_pt = e && ((m_en_clks[i] % m_div[i]) == m_div[i] - 1);
        m_hs[i]  = (h_now < m_hsl[i]) ? m_hpol[i] : ~m_hpol[i];
        m_vs[i]  = (v_now < m_vsl[i]) ? m_vpol[i] : ~m_vpol[i];
        m_fs[i]  = m_fp1[i];
        m_fp1[i] = exp_pt && (((ticks_of(i) + 1) % (m_ht[i] * m_vt[i])) == 0);
        if (e) m_en_clks[i]++;
      end
    end
    if (r) model_ok = 1'b1;
  endtask

  initial begin
    m_div[0] = A_DIV; m_hsl[0] = A_HS; m_hbp[0] = A_HBP; m_ha[0] = A_HA;
    m_ht[0]  = A_HS + A_HBP + A_HA + A_HFP;
    m_vsl[0] = A_VS; m_vbp[0] = A_VBP; m_va[0] = A_VA;
    m_vt[0]  = A_VS + A_VBP + A_VA + A_VFP;
    m_hpol[0] = 1'b0; m_vpol[0] = 1'b0;
    m_div[1] = B_DIV; m_hsl[1] = B_HS; m_hbp[1] = B_HBP; m_ha[1] = B_HA;
    m_ht[1]  = B_HS + B_HBP + B_HA + B_HFP;
    m_vsl[1] = B_VS; m_vbp[1] = B_VBP; m_va[1] = B_VA;
    m_vt[1]  = B_VS + B_VBP + B_VA + B_VFP;
    m_hpol[1] = 1'b1; m_vpol[1] = 1'b0;
    for (int i = 0; i < NI; i++) begin
      m_en_clks[i] = 0;
      m_hs[i] = 1'b0; m_vs[i] = 1'b0; m_fp1[i] = 1'b0; m_fs[i] = 1'b0;
      last_fs[i] = -1;
      gap[i] = -1;
    end

    // Margins are constants.
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("h_left[%0d]", i),  64'(hlm[i]), 64'(m_hsl[i] + m_hbp[i]));
      check($sformatf("h_right[%0d]", i), 64'(hrm[i]), 64'(m_hsl[i] + m_hbp[i] + m_ha[i] - 1));
      check($sformatf("v_left[%0d]", i),  64'(vlm[i]), 64'(m_vsl[i] + m_vbp[i]));
      check($sformatf("v_right[%0d]", i), 64'(vrm[i]), 64'(m_vsl[i] + m_vbp[i] + m_va[i] - 1));
    end

    // Initial reset, then a free run that crosses line wraps.
    repeat (3) cycle(1'b1, 1'b1);
    repeat (200) cycle(1'b0, 1'b1);

    // Reset held for 3 clks mid-line, with En still high.
    repeat (3) cycle(1'b1, 1'b1);

    // Uninterrupted run covering several frames, to measure the pulse spacing.
    for (int i = 0; i < NI; i++) gap[i] = -1;
    repeat (1200) cycle(1'b0, 1'b1);
    for (int i = 0; i < NI; i++)
      check($sformatf("frame_gap[%0d]", i), 64'(gap[i]),
            64'(longint'(m_ht[i]) * m_vt[i] * m_div[i]));

    // Freeze for 10 clks, then resume.
    repeat (10) cycle(1'b0, 1'b0);
    repeat (40) cycle(1'b0, 1'b1);

    // Randomised En drops with rare resets.
    repeat (3000) begin
      cycle(($urandom_range(0, 999) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
